ocram_pipelined: RTL and testbench
==================================

Name: ocram_pipelined

Overview:
- Parametrised on-chip RAM with an Avalon-MM pipelined slave interface. Replaces the fixed 8192x16 single-port, zero-wait memory.
- Adds configurable width, depth and read latency, plus a `waitrequest`/`readdatavalid` handshake.
- Adds a post-reset clear engine and read-after-write bypass.
- Sits on the system interconnect as program/data memory for the soft processor.

Parameters:
- DATA_W, 32, data width in bits; multiple of 8, range 8..128.
- ADDR_W, 13, word address width; DEPTH = 2**ADDR_W.
- READ_LATENCY, 2, cycles from read acceptance to `readdatavalid`; legal values 1 or 2.
- CLEAR_ON_RESET, 1, when 1, zero-fill the whole RAM after reset before accepting traffic.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  ADDR_W  word address.
- byteenable  in  DATA_W/8  write byte lanes; ignored for reads.
- chipselect  in  1  slave select.
- read  in  1  read request.
- write  in  1  write request.
- writedata  in  DATA_W  write data.
- clken  in  1  clock enable; 0 freezes the block.
- waitrequest  out  1  1 = transfer not accepted.
- readdata  out  DATA_W  read data; valid only while `readdatavalid` = 1.
- readdatavalid  out  1  one-cycle strobe per accepted read.
- init_done  out  1  1 once the clear sequence has finished.
- parity_err  out  1  see Optional Feature.

Behaviour:
- Reset values: `waitrequest` = 1, `readdatavalid` = 0, `readdata` = 0, `init_done` = 0, `parity_err` = 0. The valid pipeline and bypass register are cleared. RAM contents are not reset.
- FSM states:
  - CLEAR: entered on reset release when CLEAR_ON_RESET = 1. A counter walks 0..DEPTH-1, writing all-zero data with all byte lanes enabled, one word per cycle while `clken` = 1. `waitrequest` = 1 throughout. After the write to DEPTH-1, go to READY. Takes exactly DEPTH enabled cycles.
  - READY: `init_done` = 1. `waitrequest` = ~`clken`. If CLEAR_ON_RESET = 0, reset goes straight to READY.
- Acceptance: a transfer is accepted when `chipselect` & (`read` | `write`) & ~`waitrequest`.
- Writes: take effect at the accepting edge, only for lanes where `byteenable` = 1.
- Reads:
  - A read accepted at edge N produces `readdatavalid` = 1 with data in cycle N+READ_LATENCY.
  - One read can be accepted per cycle, giving full throughput with no bubbles.
  - `readdatavalid` strobes follow acceptance order.
- `read` and `write` asserted together: treated as a write. No `readdatavalid` is generated.
- Read-after-write bypass:
  - The last accepted write (address, data, byteenable) is held for one cycle.
  - A read accepted the next cycle to the same address returns RAM data with the enabled lanes replaced by the held write data.
  - A read accepted in the same cycle as a write is not possible (see previous rule).
  - Reads two or more cycles after a write come from RAM directly.
- `clken` = 0:
  - No transfer is accepted.
  - The clear counter, read pipeline and bypass register hold their values.
  - `readdatavalid` is forced to 0.
  - A pending read emerges with the same relative delay once `clken` returns to 1.
- Address wrap: the clear counter stops at DEPTH-1; it does not wrap. Bus addresses are always in range because the width is exact.
- Reset mid-operation:
  - Pending `readdatavalid` strobes are discarded.
  - A clear in progress restarts from address 0.
  - Writes already taken are kept in RAM.
- RAM: inferred simple dual-port, synchronous read, registered address, so native latency is 1. With READ_LATENCY = 2, one output register stage is added.

Optional Feature:
- Macro: OCRAM_PARITY_EN.
- With the macro defined:
  - One even-parity bit per byte is stored alongside the data; the RAM width becomes DATA_W + DATA_W/8.
  - CLEAR writes parity 0.
  - Every read recomputes parity over the returned data. `parity_err` = 1 in the `readdatavalid` cycle if any lane mismatches.
  - Bypassed lanes use the held write parity.
- Without the macro: no parity storage, and `parity_err` is tied to 0.

Decomposition:
- Package `ocram_pkg` holds:
  - the FSM state enum {CLEAR, READY};
  - the function `byte_parity(data)`;
  - the constant `MAX_READ_LATENCY = 2`.
- One sub-module, `ocram_sdp_ram`:
  - parametrised width and depth;
  - byte-enabled write port and synchronous read port;
  - no reset.
- The top level holds the FSM, clear counter, bypass register and valid pipeline.

Test Plan:
- Reset release, CLEAR_ON_RESET = 1, ADDR_W = 4 → `waitrequest` = 1 for exactly 16 cycles, then `init_done` = 1; reads of 0..15 all return 0.
- Write 0xDEADBEEF to address 0x5 with `byteenable` = 4'b0101, then read 0x5 in the next cycle → `readdata` = 0x00AD00EF (bypass path); the same read 3 cycles later returns the same value from RAM.
- Back-to-back reads of addresses 1, 2, 3, READ_LATENCY = 2 → `readdatavalid` in cycles N+2, N+3, N+4 with matching data; no bubbles.
- `clken` driven to 0 for 3 cycles, starting the cycle after a read is accepted → `readdatavalid` delayed by exactly 3 cycles; data is correct.
- `reset_n` asserted halfway through CLEAR and while a read is in flight → no `readdatavalid` appears; after release the clear restarts and takes the full 16 cycles.
- OCRAM_PARITY_EN defined: force a bit flip in a stored data bit via hierarchical deposit, then read → `parity_err` = 1 coincident with `readdatavalid`; an unflipped read gives 0.

Source files
------------

// File: rtl/ocram_pkg.sv
// Shared types and helpers for the pipelined on-chip RAM.
// Optional per-byte parity storage is enabled by defining OCRAM_PARITY_EN.
package ocram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } ocram_state_t;

  localparam int MAX_READ_LATENCY = 2;

  // Even parity: the returned bit makes the total count of ones even.
  function automatic logic byte_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/ocram_sdp_ram.sv
// Simple dual-port RAM, byte-lane write enables, registered synchronous read.
// Lane width is a parameter so parity bits (OCRAM_PARITY_EN) can ride with each byte.
module ocram_sdp_ram #(
  parameter int LANE_W = 8,
  parameter int LANES  = 4,
  parameter int ADDR_W = 13
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [ADDR_W-1:0]         waddr,
  input  logic [LANES-1:0]          wbe,
  input  logic [LANES*LANE_W-1:0]   wdata,
  input  logic                      re,
  input  logic [ADDR_W-1:0]         raddr,
  output logic [LANES*LANE_W-1:0]   rdata
);

  logic [LANES*LANE_W-1:0] mem [2**ADDR_W];

  // Byte-lane write and registered read; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (wbe[i]) begin
          mem[waddr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
        end
      end
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/ocram_pipelined.sv
// Avalon-MM pipelined on-chip RAM: post-reset clear, read-after-write bypass, 1/2-cycle read latency.
// Define OCRAM_PARITY_EN to store and check one even-parity bit per byte.
module ocram_pipelined
  import ocram_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 13,
  parameter int READ_LATENCY   = 2,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W/8-1:0]   byteenable,
  input  logic                  chipselect,
  input  logic                  read,
  input  logic                  write,
  input  logic [DATA_W-1:0]     writedata,
  input  logic                  clken,
  output logic                  waitrequest,
  output logic [DATA_W-1:0]     readdata,
  output logic                  readdatavalid,
  output logic                  init_done,
  output logic                  parity_err
);

  localparam int LANES = DATA_W / 8;
`ifdef OCRAM_PARITY_EN
  localparam int LANE_W = 9;
`else
  localparam int LANE_W = 8;
`endif
  localparam int RAM_W   = LANES * LANE_W;
  localparam int EFF_LAT = (READ_LATENCY >= MAX_READ_LATENCY) ? MAX_READ_LATENCY : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  ocram_state_t         state_r, state_nxt_s;
  logic [ADDR_W-1:0]    clr_addr_r, clr_addr_nxt_s;
  logic                 clr_we_s, wr_acc_s, rd_acc_s;

  logic                 ram_we_s;
  logic [ADDR_W-1:0]    ram_waddr_s;
  logic [LANES-1:0]     ram_wbe_s;
  logic [RAM_W-1:0]     ram_wdata_s, ram_q_s, wr_lanes_s, merged_lanes_s;

  logic                 hold_v_r;
  logic [ADDR_W-1:0]    hold_addr_r;
  logic [LANES-1:0]     hold_be_r;
  logic [RAM_W-1:0]     hold_lanes_r;

  logic                 v1_r;
  logic [LANES-1:0]     byp_be1_r;
  logic [RAM_W-1:0]     byp_lanes1_r;

  logic [DATA_W-1:0]    merged_data_s;
  logic                 err_s, out_err_s;

  assign init_done   = (state_r == READY);
  assign waitrequest = ~((state_r == READY) & clken);

  // Bus acceptance; read+write together counts as a write only.
  always_comb begin
    wr_acc_s = 1'b0;
    rd_acc_s = 1'b0;
    if (chipselect && !waitrequest) begin
      wr_acc_s = write;
      rd_acc_s = read & ~write;
    end else begin
      wr_acc_s = 1'b0;
      rd_acc_s = 1'b0;
    end
  end

  // Clear sequencer next-state logic.
  always_comb begin
    state_nxt_s    = state_r;
    clr_addr_nxt_s = clr_addr_r;
    clr_we_s       = 1'b0;
    case (state_r)
      CLEAR: begin
        if (CLEAR_ON_RESET == 0) begin
          state_nxt_s = READY;
        end else if (clken) begin
          clr_we_s = 1'b1;
          if (clr_addr_r == LAST_ADDR) begin
            state_nxt_s = READY;
          end else begin
            clr_addr_nxt_s = clr_addr_r + 1'b1;
          end
        end else begin
          clr_we_s = 1'b0;
        end
      end
      READY:   state_nxt_s = READY;
      default: state_nxt_s = CLEAR;
    endcase
  end

  // State register and clear counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= CLEAR;
      clr_addr_r <= '0;
    end else begin
      state_r    <= state_nxt_s;
      clr_addr_r <= clr_addr_nxt_s;
    end
  end

  // Lane packing of write data (plus per-byte parity when enabled) and lane merge on read.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign wr_lanes_s[i*LANE_W +: 8] = writedata[i*8 +: 8];
    assign merged_lanes_s[i*LANE_W +: LANE_W] = byp_be1_r[i] ? byp_lanes1_r[i*LANE_W +: LANE_W]
                                                             : ram_q_s[i*LANE_W +: LANE_W];
    assign merged_data_s[i*8 +: 8] = merged_lanes_s[i*LANE_W +: 8];
`ifdef OCRAM_PARITY_EN
    assign wr_lanes_s[i*LANE_W + 8] = byte_parity(writedata[i*8 +: 8]);
`endif
  end

`ifdef OCRAM_PARITY_EN
  logic [LANES-1:0] lane_err_s;
  for (genvar i = 0; i < LANES; i++) begin : g_chk
    assign lane_err_s[i] = merged_lanes_s[i*LANE_W + 8] != byte_parity(merged_lanes_s[i*LANE_W +: 8]);
  end
  assign err_s = |lane_err_s;
`else
  assign err_s = 1'b0;
`endif

  assign ram_we_s    = clr_we_s | wr_acc_s;
  assign ram_waddr_s = clr_we_s ? clr_addr_r : address;
  assign ram_wbe_s   = clr_we_s ? {LANES{1'b1}} : byteenable;
  assign ram_wdata_s = clr_we_s ? {RAM_W{1'b0}} : wr_lanes_s;

  ocram_sdp_ram #(
    .LANE_W (LANE_W),
    .LANES  (LANES),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .waddr (ram_waddr_s),
    .wbe   (ram_wbe_s),
    .wdata (ram_wdata_s),
    .re    (rd_acc_s),
    .raddr (address),
    .rdata (ram_q_s)
  );

  // Held write for bypass and first read-pipeline stage; both freeze while clken is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_v_r     <= 1'b0;
      hold_addr_r  <= '0;
      hold_be_r    <= '0;
      hold_lanes_r <= '0;
      v1_r         <= 1'b0;
      byp_be1_r    <= '0;
      byp_lanes1_r <= '0;
    end else if (clken) begin
      hold_v_r <= wr_acc_s;
      if (wr_acc_s) begin
        hold_addr_r  <= address;
        hold_be_r    <= byteenable;
        hold_lanes_r <= wr_lanes_s;
      end else begin
        hold_addr_r  <= hold_addr_r;
      end
      v1_r <= rd_acc_s;
      if (rd_acc_s) begin
        byp_be1_r    <= (hold_v_r && (hold_addr_r == address)) ? hold_be_r : {LANES{1'b0}};
        byp_lanes1_r <= hold_lanes_r;
      end else begin
        byp_be1_r    <= byp_be1_r;
      end
    end else begin
      hold_v_r <= hold_v_r;
    end
  end

  if (EFF_LAT == 1) begin : g_lat1
    assign readdatavalid = v1_r & clken;
    assign readdata      = v1_r ? merged_data_s : {DATA_W{1'b0}};
    assign out_err_s     = err_s;
  end else begin : g_lat2
    logic              v2_r;
    logic              err2_r;
    logic [DATA_W-1:0] rd2_r;

    // Output register stage for two-cycle latency.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        v2_r   <= 1'b0;
        err2_r <= 1'b0;
        rd2_r  <= '0;
      end else if (clken) begin
        v2_r   <= v1_r;
        err2_r <= v1_r & err_s;
        rd2_r  <= merged_data_s;
      end else begin
        v2_r   <= v2_r;
      end
    end

    assign readdatavalid = v2_r & clken;
    assign readdata      = rd2_r;
    assign out_err_s     = err2_r;
  end

  assign parity_err = readdatavalid & out_err_s;

endmodule

// File: tb/tb_ocram_pipelined.sv
// Directed, table-driven bench for ocram_pipelined (ADDR_W=4, DATA_W=32, latency 2).
// Parity checks are compiled in when OCRAM_PARITY_EN is defined.
module tb_ocram_pipelined;

  localparam int RL = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  address;
  logic [3:0]  byteenable;
  logic        chipselect, read, write, clken;
  logic [31:0] writedata;
  logic        waitrequest, readdatavalid, init_done, parity_err;
  logic [31:0] readdata;

  int total = 0;
  int passed = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] data;
    logic        perr;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic        wr;
    logic        rd;
    logic [3:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[17];

  ocram_pipelined #(
    .DATA_W(32), .ADDR_W(4), .READ_LATENCY(RL), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .waitrequest(waitrequest), .readdata(readdata),
    .readdatavalid(readdatavalid), .init_done(init_done), .parity_err(parity_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input longint act, input longint expv);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  // Every readdatavalid strobe must match the next expected read, in the expected cycle.
  always @(negedge clk) begin
    if (readdatavalid) begin
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL spurious_valid: got data %0h at cycle %0d expected no strobe", readdata, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (readdata === e.data && parity_err === e.perr && cyc == e.cyc) passed++;
        else $display("FAIL read: got data %0h perr %0b cycle %0d expected data %0h perr %0b cycle %0d",
                      readdata, parity_err, cyc, e.data, e.perr, e.cyc);
      end
    end
  end

  task automatic idle();
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
  endtask

  // Present one transfer (call at posedge+1); expected read results go to the queue.
  task automatic issue(input logic wr, input logic rd, input logic [3:0] a, input logic [3:0] be,
                       input logic [31:0] d, input logic [31:0] expv, input logic ep);
    chipselect = 1'b1; write = wr; read = rd; address = a; byteenable = be; writedata = d;
    @(posedge clk); #1;
    if (rd && !wr) exp_q.push_back('{expv, ep, cyc + RL - 1});
  endtask

  task automatic wait_init(input int expn, input string name);
    int n = 0;
    int wr_hi = 0;
    while (!init_done && n < 100) begin
      if (waitrequest) wr_hi++;
      @(posedge clk); #1;
      n++;
    end
    check(n == expn, {name, "_cycles"}, n, expn);
    check(wr_hi == expn, {name, "_waitreq_high"}, wr_hi, expn);
    check(waitrequest == 1'b0, {name, "_waitreq_after"}, waitrequest, 0);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 4'h5, 4'b0101, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 4'h5, 4'b0000, 32'h0,        32'h00AD00EF};
    vecs[2]  = '{1'b1, 1'b0, 4'h1, 4'b1111, 32'h11111111, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 4'h2, 4'b0011, 32'hAAAA2222, 32'h0};
    vecs[4]  = '{1'b0, 1'b1, 4'h5, 4'b0000, 32'h0,        32'h00AD00EF};
    vecs[5]  = '{1'b1, 1'b0, 4'h3, 4'b1100, 32'h3333BBBB, 32'h0};
    vecs[6]  = '{1'b0, 1'b1, 4'h1, 4'b0000, 32'h0,        32'h11111111};
    vecs[7]  = '{1'b0, 1'b1, 4'h2, 4'b0000, 32'h0,        32'h00002222};
    vecs[8]  = '{1'b0, 1'b1, 4'h3, 4'b0000, 32'h0,        32'h33330000};
    vecs[9]  = '{1'b1, 1'b0, 4'h3, 4'b0011, 32'hCCCC4444, 32'h0};
    vecs[10] = '{1'b0, 1'b1, 4'h3, 4'b0000, 32'h0,        32'h33334444};
    vecs[11] = '{1'b1, 1'b0, 4'h5, 4'b1010, 32'h12345678, 32'h0};
    vecs[12] = '{1'b1, 1'b0, 4'h6, 4'b1111, 32'h0,        32'h0};
    vecs[13] = '{1'b0, 1'b1, 4'h5, 4'b0000, 32'h0,        32'h12AD56EF};
    vecs[14] = '{1'b0, 1'b1, 4'h6, 4'b0000, 32'h0,        32'h00000000};
    vecs[15] = '{1'b1, 1'b1, 4'h7, 4'b1111, 32'h77777777, 32'h0};
    vecs[16] = '{1'b0, 1'b1, 4'h7, 4'b0000, 32'h0,        32'h77777777};

    reset_n = 1'b0; clken = 1'b1; address = 4'h0; byteenable = 4'h0; writedata = 32'h0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    check(waitrequest == 1'b1, "rst_waitrequest", waitrequest, 1);
    check(readdatavalid == 1'b0, "rst_readdatavalid", readdatavalid, 0);
    check(readdata == 32'h0, "rst_readdata", readdata, 0);
    check(init_done == 1'b0, "rst_init_done", init_done, 0);
    check(parity_err == 1'b0, "rst_parity_err", parity_err, 0);

    reset_n = 1'b1;
    wait_init(16, "clear");

    for (int a = 0; a < 16; a++) issue(1'b0, 1'b1, 4'(a), 4'h0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 17; i++)
      issue(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].be, vecs[i].wdata, vecs[i].exp, 1'b0);
    idle();
    repeat (4) @(posedge clk);
    #1;

    // Read accepted, then clken low for three cycles: strobe slips by exactly three.
    chipselect = 1'b1; read = 1'b1; address = 4'h2;
    @(posedge clk); #1;
    exp_q.push_back('{32'h00002222, 1'b0, cyc + RL - 1 + 3});
    idle();
    clken = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check(waitrequest == 1'b1, "clken_low_waitrequest", waitrequest, 1);
    clken = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Reset while a read is in flight, then again halfway through the clear.
    chipselect = 1'b1; read = 1'b1; address = 4'h1;
    @(posedge clk); #1;
    idle();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check(init_done == 1'b0, "mid_clear_init_done", init_done, 0);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    wait_init(16, "restart_clear");
    issue(1'b0, 1'b1, 4'h5, 4'h0, 32'h0, 32'h0, 1'b0);
    issue(1'b0, 1'b1, 4'h7, 4'h0, 32'h0, 32'h0, 1'b0);
    idle();

`ifdef OCRAM_PARITY_EN
    issue(1'b1, 1'b0, 4'h9, 4'hF, 32'h000000FF, 32'h0, 1'b0);
    idle();
    repeat (2) @(posedge clk);
    #1;
    dut.u_ram.mem[9][0] = ~dut.u_ram.mem[9][0];
    issue(1'b0, 1'b1, 4'h9, 4'h0, 32'h0, 32'h000000FE, 1'b1);
    issue(1'b0, 1'b1, 4'h0, 4'h0, 32'h0, 32'h00000000, 1'b0);
    idle();
`endif

    repeat (6) @(posedge clk);
    #1;
    check(exp_q.size() == 0, "missing_strobes", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
